// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared definitions for the execute->memory and memory->write-back
// pipeline buses, mem_control field positions, access size codes and the
// memory-stage FSM states.
package cpu_bus_pkg;

    localparam int unsigned EXE_MEM_BUS_W = 157;
    localparam int unsigned MEM_WB_BUS_W  = 121;

    // mem_control bit positions ([0] carries no meaning in this stage)
    localparam int unsigned MC_LOAD    = 5;
    localparam int unsigned MC_STORE   = 4;
    localparam int unsigned MC_SIZE_HI = 3;
    localparam int unsigned MC_SIZE_LO = 2;
    localparam int unsigned MC_SIGN    = 1;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11   // treated as word
    } mem_size_e;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_WAIT = 2'b01,
        MS_DONE = 2'b10
    } mem_state_e;

    typedef struct packed {
        logic [5:0]  mem_control;
        logic [31:0] store_data;
        logic [31:0] exe_result;
        logic [31:0] lo_result;
        logic        hi_write;
        logic        lo_write;
        logic        mfhi;
        logic        mflo;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  cp0r_addr;
        logic        syscall;
        logic        brk;
        logic        eret;
        logic        rf_wen;
        logic [4:0]  rf_wdest;
        logic [31:0] pc;
    } exe_mem_bus_t;

    typedef struct packed {
        logic        rf_wen;
        logic [4:0]  rf_wdest;
        logic [31:0] mem_result;
        logic [31:0] lo_result;
        logic        hi_write;
        logic        lo_write;
        logic        mfhi;
        logic        mflo;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  cp0r_addr;
        logic        syscall;
        logic        brk;
        logic        eret;
        logic        adel;
        logic        ades;
        logic [31:0] pc;
    } mem_wb_bus_t;

    // Natural alignment check: halves need addr[0]=0, words (and the
    // reserved size) need addr[1:0]=0.
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lsb);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lsb[0];
            default: return |lsb;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half lane of a little-endian RAM word
// and zero- or sign-extends it to 32 bits. Words pass through unchanged.
//   rdata_i  in  32  raw RAM word
//   addr_i   in  2   low address bits (lane select)
//   size_i   in  2   access size code
//   sign_i   in  1   1: sign-extend byte/half, 0: zero-extend
//   data_o   out 32  aligned, extended load data
module load_align
    import cpu_bus_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  mem_size_e   size_i,
    input  logic        sign_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    always_comb begin
        case (addr_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            default: byte_s = rdata_i[31:24];
        endcase
        half_s = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            SZ_BYTE: data_o = {{24{sign_i & byte_s[7]}}, byte_s};
            SZ_HALF: data_o = {{16{sign_i & half_s[15]}}, half_s};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage of the 5-stage pipeline. Issues loads/stores to a
// synchronous data RAM, aligns load data, flags misaligned accesses and holds
// the instruction until the write-back stage accepts it (MEM_adv).
//   clk, reset      clock / synchronous active-high reset
//   MEM_valid       stage holds a valid instruction
//   EXE_MEM_bus_r   registered execute->memory bus (157b)
//   MEM_adv         write-back latches MEM_WB_bus this cycle
//   MEM_over        stage result is final
//   MEM_WB_bus      memory->write-back bus (121b)
//   dm_addr/dm_wen/dm_wdata/dm_rdata  data RAM interface (read latency 1)
//   MEM_wdest       destination register for hazard detection
//   MEM_pc          pc of the instruction in this stage
module mem_access
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MEM_valid,
    input  logic [EXE_MEM_BUS_W-1:0] EXE_MEM_bus_r,
    input  logic                     MEM_adv,
    output logic                     MEM_over,
    output logic [MEM_WB_BUS_W-1:0]  MEM_WB_bus,
    output logic [ADDR_W-1:0]        dm_addr,
    output logic [3:0]               dm_wen,
    output logic [31:0]              dm_wdata,
    input  logic [31:0]              dm_rdata,
    output logic [4:0]               MEM_wdest,
    output logic [31:0]              MEM_pc
);

    exe_mem_bus_t in_s;
    mem_wb_bus_t  out_s;
    mem_size_e    size_s;
    logic         is_load_s;
    logic         is_store_s;
    logic         misal_s;
    logic         adel_s;
    logic         ades_s;
    logic [31:0]  aligned_s;
    logic [31:0]  load_res_s;
    logic [3:0]   store_wen_s;
    logic [3:0]   wen_raw_s;
    logic         unused_mc0;

    mem_state_e   state_q, state_d;
    logic [31:0]  load_data_q, load_data_d;

    assign in_s       = EXE_MEM_bus_r;
    assign size_s     = mem_size_e'(in_s.mem_control[MC_SIZE_HI:MC_SIZE_LO]);
    assign is_load_s  = in_s.mem_control[MC_LOAD];
    assign is_store_s = in_s.mem_control[MC_STORE];
    assign unused_mc0 = in_s.mem_control[0];

    assign misal_s = CHECK_ALIGN & is_misaligned(size_s, in_s.exe_result[1:0]);
    assign adel_s  = is_load_s & misal_s;
    assign ades_s  = is_store_s & misal_s;

    assign dm_addr   = {in_s.exe_result[ADDR_W-1:2], 2'b00};
    assign MEM_wdest = in_s.rf_wdest & {5{MEM_valid}};
    assign MEM_pc    = in_s.pc;

    load_align u_load_align (
        .rdata_i (dm_rdata),
        .addr_i  (in_s.exe_result[1:0]),
        .size_i  (size_s),
        .sign_i  (in_s.mem_control[MC_SIGN]),
        .data_o  (aligned_s)
    );

    // Store lane replication and byte enables
    always_comb begin
        case (size_s)
            SZ_BYTE: begin
                dm_wdata    = {4{in_s.store_data[7:0]}};
                store_wen_s = 4'b0001 << in_s.exe_result[1:0];
            end
            SZ_HALF: begin
                dm_wdata    = {2{in_s.store_data[15:0]}};
                store_wen_s = 4'b0011 << {in_s.exe_result[1], 1'b0};
            end
            default: begin
                dm_wdata    = in_s.store_data;
                store_wen_s = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MS_IDLE;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            load_data_q <= load_data_d;
        end
    end

    // A completed but stalled instruction parks in DONE so a store is written
    // exactly once and a load keeps the value captured in WAIT.
    always_comb begin
        state_d     = state_q;
        load_data_d = load_data_q;
        MEM_over    = 1'b0;
        wen_raw_s   = '0;
        load_res_s  = load_data_q;
        case (state_q)
            MS_IDLE: begin
                if (MEM_valid) begin
                    if (is_load_s && !adel_s) begin
                        state_d = MS_WAIT;
                    end else begin
                        MEM_over = 1'b1;
                        if (is_store_s && !ades_s) wen_raw_s = store_wen_s;
                        state_d = MEM_adv ? MS_IDLE : MS_DONE;
                    end
                end
            end
            MS_WAIT: begin
                MEM_over    = 1'b1;
                load_res_s  = aligned_s;
                load_data_d = aligned_s;
                state_d     = MEM_adv ? MS_IDLE : MS_DONE;
            end
            MS_DONE: begin
                MEM_over = 1'b1;
                if (MEM_adv) state_d = MS_IDLE;
            end
            default: state_d = MS_IDLE;
        endcase
    end

    assign dm_wen = reset ? 4'b0000 : wen_raw_s;

    always_comb begin
        out_s            = '0;
        out_s.rf_wen     = in_s.rf_wen & ~adel_s & MEM_valid;
        out_s.rf_wdest   = in_s.rf_wdest;
        out_s.mem_result = (is_load_s && !adel_s) ? load_res_s : in_s.exe_result;
        out_s.lo_result  = in_s.lo_result;
        out_s.hi_write   = in_s.hi_write;
        out_s.lo_write   = in_s.lo_write;
        out_s.mfhi       = in_s.mfhi;
        out_s.mflo       = in_s.mflo;
        out_s.mtc0       = in_s.mtc0;
        out_s.mfc0       = in_s.mfc0;
        out_s.cp0r_addr  = in_s.cp0r_addr;
        out_s.syscall    = in_s.syscall;
        out_s.brk        = in_s.brk;
        out_s.eret       = in_s.eret;
        out_s.adel       = adel_s;
        out_s.ades       = ades_s;
        out_s.pc         = in_s.pc;
    end

    assign MEM_WB_bus = out_s;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: drives mem_access with directed and random instructions
// against a synchronous RAM and an arithmetic reference of load/store rules.
module tb_mem_access;

    logic         clk = 1'b0;
    logic         reset;
    logic         MEM_valid;
    logic [156:0] EXE_MEM_bus_r;
    logic         MEM_adv;
    logic         MEM_over;
    logic [120:0] MEM_WB_bus;
    logic [31:0]  dm_addr;
    logic [3:0]   dm_wen;
    logic [31:0]  dm_wdata;
    logic [31:0]  dm_rdata;
    logic [4:0]   MEM_wdest;
    logic [31:0]  MEM_pc;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];
    logic        poke_en  = 1'b0;
    logic [7:0]  poke_idx = '0;
    logic [31:0] poke_val = '0;

    mem_access #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .MEM_valid     (MEM_valid),
        .EXE_MEM_bus_r (EXE_MEM_bus_r),
        .MEM_adv       (MEM_adv),
        .MEM_over      (MEM_over),
        .MEM_WB_bus    (MEM_WB_bus),
        .dm_addr       (dm_addr),
        .dm_wen        (dm_wen),
        .dm_wdata      (dm_wdata),
        .dm_rdata      (dm_rdata),
        .MEM_wdest     (MEM_wdest),
        .MEM_pc        (MEM_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (poke_en) ram[poke_idx] <= poke_val;
        for (int i = 0; i < 4; i++)
            if (dm_wen[i]) ram[dm_addr[9:2]][8*i +: 8] <= dm_wdata[8*i +: 8];
        dm_rdata <= ram[dm_addr[9:2]];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: shift the word down to the addressed lane, mask, sign-fix.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input int unsigned a,
                                             input int unsigned sz, input bit sgn);
        logic [31:0] v;
        if (sz == 0) begin
            v = (w >> (a * 8)) & 32'hFF;
            if (sgn && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 1) begin
            v = (w >> ((a / 2) * 16)) & 32'hFFFF;
            if (sgn && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic poke_word(input int unsigned idx, input logic [31:0] val);
        poke_en  = 1'b1;
        poke_idx = 8'(idx);
        poke_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Issue one instruction; hold it `stall` extra MEM_over cycles before MEM_adv.
    task automatic run_instr(input logic [5:0] mc, input logic [31:0] addr, input logic [31:0] sd,
                             input int stall, input bit clobber);
        logic [31:0] lo, pc, word, exp_res, exp_wdata;
        logic [5:0]  m6;
        logic [7:0]  cp;
        logic [2:0]  m3;
        logic        rw;
        logic [4:0]  wd;
        logic [3:0]  exp_wen;
        logic [120:0] exp_bus;
        int unsigned sz, a, idx, nat;
        bit isld, isst, mis, adel, ades, done;
        int first, waited, wen_cyc, exp_lat, exp_wc;

        lo = $urandom; pc = $urandom; m6 = 6'($urandom); cp = 8'($urandom);
        m3 = 3'($urandom); rw = 1'($urandom); wd = 5'($urandom);
        sz = int'(mc[3:2]); a = addr % 4; idx = (addr / 4) % 256;
        isld = mc[5]; isst = mc[4];
        nat = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        mis = (addr % nat) != 0;
        adel = isld && mis;
        ades = isst && mis;
        word = ref_mem[idx];
        exp_res = (isld && !adel) ? ref_load(word, a, sz, mc[1]) : addr;
        exp_wen = (sz == 0) ? 4'(1 << a) : (sz == 1) ? 4'(3 << (a & 2)) : 4'hF;
        exp_wdata = (sz == 0) ? sd[7:0] * 32'h01010101 :
                    (sz == 1) ? sd[15:0] * 32'h00010001 : sd;
        exp_lat = (isld && !adel) ? 2 : 1;
        exp_wc  = (isst && !ades) ? 1 : 0;
        exp_bus = {rw & ~adel, wd, exp_res, lo, m6, cp, m3, adel, ades, pc};

        EXE_MEM_bus_r = {mc, sd, addr, lo, m6, cp, m3, rw, wd, pc};
        MEM_valid = 1'b1;
        MEM_adv   = 1'b0;
        first = 0; waited = 0; wen_cyc = 0; done = 0;
        for (int c = 1; c <= 20 && !done; c++) begin
            #1;
            if (c == 1) check("wdest", 128'(MEM_wdest), 128'(wd));
            if (dm_wen != 4'b0000) begin
                wen_cyc++;
                check("dm_wen", 128'(dm_wen), 128'(exp_wen));
                check("dm_wdata", 128'(dm_wdata), 128'(exp_wdata));
            end
            if (MEM_over) begin
                if (first == 0) begin
                    first = c;
                    check("over_latency", 128'(c), 128'(exp_lat));
                end
                check("mem_wb_bus", 128'(MEM_WB_bus), 128'(exp_bus));
                if (clobber && waited == 0) begin
                    poke_en  = 1'b1;
                    poke_idx = 8'(idx);
                    poke_val = ~word;
                    ref_mem[idx] = ~word;
                end
                if (waited == stall) MEM_adv = 1'b1;
                else waited++;
            end
            @(posedge clk);
            if (MEM_adv) done = 1;
            @(negedge clk);
            poke_en = 1'b0;
        end
        if (!done) check("adv_timeout", 128'(0), 128'(1));
        MEM_valid = 1'b0;
        MEM_adv   = 1'b0;
        if (exp_wc == 1)
            for (int i = 0; i < 4; i++)
                if (exp_wen[i]) ref_mem[idx][8*i +: 8] = exp_wdata[8*i +: 8];
        #1;
        check("idle_over", 128'(MEM_over), 128'(0));
        check("idle_wen", 128'(dm_wen), 128'(0));
        check("wen_cycles", 128'(wen_cyc), 128'(exp_wc));
    endtask

    initial begin
        reset = 1'b1;
        MEM_valid = 1'b0;
        MEM_adv = 1'b0;
        EXE_MEM_bus_r = '0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) poke_word(i, $urandom);
        #1;
        check("rst_over", 128'(MEM_over), 128'(0));
        check("rst_wen", 128'(dm_wen), 128'(0));
        check("rst_wdest", 128'(MEM_wdest), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // lw, immediate advance
        poke_word(32'h100 / 4, 32'hDEADBEEF);
        run_instr(6'b101000, 32'h100, 32'h0, 0, 0);

        // sub-word loads from 0x80FF_0000
        poke_word(32'h100 / 4, 32'h80FF0000);
        run_instr(6'b100010, 32'h103, 32'h0, 0, 0);   // lb
        run_instr(6'b100000, 32'h103, 32'h0, 0, 0);   // lbu
        run_instr(6'b100110, 32'h102, 32'h0, 0, 0);   // lh
        run_instr(6'b100100, 32'h102, 32'h0, 1, 0);   // lhu, stalled

        // stalled sb writes exactly once
        run_instr(6'b010000, 32'h201, 32'h000000AB, 3, 0);
        run_instr(6'b101000, 32'h200, 32'h0, 0, 0);

        // misaligned load / store
        run_instr(6'b101000, 32'h102, 32'h0, 0, 0);
        run_instr(6'b010100, 32'h201, 32'h1234, 2, 0);

        // stalled load, RAM rewritten while parked
        poke_word(32'h300 / 4, 32'h13579BDF);
        run_instr(6'b101000, 32'h300, 32'h0, 3, 1);

        // reset during WAIT, then a store presented while reset still high
        EXE_MEM_bus_r = {6'b101000, 32'h0, 32'h40, 32'h0, 6'h0, 8'h0, 3'h0, 1'b1, 5'd3, 32'h400};
        MEM_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("wait_over", 128'(MEM_over), 128'(1));
        reset = 1'b1;
        MEM_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        EXE_MEM_bus_r = {6'b011000, 32'hCAFEF00D, 32'h40, 32'h0, 6'h0, 8'h0, 3'h0, 1'b0, 5'd0, 32'h404};
        MEM_valid = 1'b1;
        #1;
        check("rst_force_wen", 128'(dm_wen), 128'(0));
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        MEM_valid = 1'b0;
        #1;
        check("post_rst_over", 128'(MEM_over), 128'(0));
        check("post_rst_wen", 128'(dm_wen), 128'(0));
        @(negedge clk);
        run_instr(6'b000000, 32'h2A4, 32'h0, 0, 0);   // addu
        run_instr(6'b101000, 32'h40, 32'h0, 0, 0);    // untouched by the squashed store

        for (int n = 0; n < 80; n++) begin
            logic [5:0] mc;
            int kind;
            kind = $urandom_range(0, 2);
            mc = 6'($urandom);
            mc[5] = (kind == 0);
            mc[4] = (kind == 1);
            run_instr(mc, 32'($urandom_range(0, 1023)), $urandom, $urandom_range(0, 3), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
